// File: rtl/snoop_ac_multicast.sv
// snoop_ac_multicast: fans one upstream AC snoop out to selected masters and merges their CR responses.
module snoop_ac_multicast #(
    parameter int unsigned NumPorts     = 4,
    parameter int unsigned AddrWidth    = 64,
    parameter bit          DvmBroadcast = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    slv_ac_valid_i,
    output logic                    slv_ac_ready_o,
    input  logic [AddrWidth-1:0]    slv_ac_addr_i,
    input  logic [3:0]              slv_ac_snoop_i,
    input  logic [2:0]              slv_ac_prot_i,
    input  logic [NumPorts-1:0]     slv_ac_mask_i,
    output logic [NumPorts-1:0]     mst_ac_valid_o,
    input  logic [NumPorts-1:0]     mst_ac_ready_i,
    output logic [AddrWidth-1:0]    mst_ac_addr_o,
    output logic [3:0]              mst_ac_snoop_o,
    output logic [2:0]              mst_ac_prot_o,
    input  logic [NumPorts-1:0]     mst_cr_valid_i,
    output logic [NumPorts-1:0]     mst_cr_ready_o,
    input  logic [NumPorts*5-1:0]   mst_cr_resp_i,
    output logic                    slv_cr_valid_o,
    input  logic                    slv_cr_ready_i,
    output logic [4:0]              slv_cr_resp_o,
    output logic [NumPorts-1:0]     slv_cr_src_o,
    output logic                    busy_o
);
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } crresp_t;
    typedef logic [3:0] acsnoop_t;
    typedef logic [2:0] acprot_t;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 r_state, w_state_nxt;
    logic [AddrWidth-1:0]   r_addr;
    acsnoop_t               r_snoop;
    acprot_t                r_prot;
    crresp_t                r_resp, w_resp_nxt;
    logic [NumPorts-1:0]    r_pend_ac, r_pend_cr, r_src;
    logic [NumPorts-1:0]    w_eff_mask, w_cr_hs, w_pend_ac_nxt, w_pend_cr_nxt, w_src_nxt;
    logic                   w_ac_hs, w_pd_seen, w_pd_multi;

    assign slv_ac_ready_o = (r_state == IDLE) & ~rst_i;
    assign w_ac_hs        = slv_ac_valid_i & slv_ac_ready_o;
    assign w_eff_mask     = (DvmBroadcast && slv_ac_snoop_i[3:1] == 3'b111) ? '1 : slv_ac_mask_i;
    assign mst_ac_valid_o = r_pend_ac;
    // CR is only taken from ports whose AC already completed in an earlier cycle
    assign mst_cr_ready_o = r_pend_cr & ~r_pend_ac;
    assign w_cr_hs        = mst_cr_valid_i & mst_cr_ready_o;
    assign w_pend_ac_nxt  = r_pend_ac & ~(mst_ac_valid_o & mst_ac_ready_i);
    assign w_pend_cr_nxt  = r_pend_cr & ~w_cr_hs;
    assign mst_ac_addr_o  = r_addr;
    assign mst_ac_snoop_o = r_snoop;
    assign mst_ac_prot_o  = r_prot;
    assign slv_cr_valid_o = (r_state == RESP);
    assign slv_cr_resp_o  = r_resp;
    assign slv_cr_src_o   = r_src;
    assign busy_o         = (r_state != IDLE);

    // a second dirty owner, in this cycle or any earlier one, is a coherency error
    always_comb begin
        w_resp_nxt = r_resp;
        w_src_nxt  = r_src;
        w_pd_seen  = r_resp.pass_dirty;
        w_pd_multi = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            if (w_cr_hs[i]) begin
                w_resp_nxt   = crresp_t'(w_resp_nxt | mst_cr_resp_i[5*i +: 5]);
                w_src_nxt[i] = mst_cr_resp_i[5*i];
                w_pd_multi   = w_pd_multi | (w_pd_seen & mst_cr_resp_i[5*i+2]);
                w_pd_seen    = w_pd_seen | mst_cr_resp_i[5*i+2];
            end
        end
        w_resp_nxt.error = w_resp_nxt.error | w_pd_multi;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_ac_hs) w_state_nxt = (w_eff_mask == '0) ? RESP : WAIT;
            WAIT:    if (w_pend_ac_nxt == '0 && w_pend_cr_nxt == '0) w_state_nxt = RESP;
            RESP:    if (slv_cr_ready_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_snoop   <= '0;
            r_prot    <= '0;
            r_resp    <= '0;
            r_src     <= '0;
            r_pend_ac <= '0;
            r_pend_cr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ac_hs) begin
                r_addr    <= slv_ac_addr_i;
                r_snoop   <= slv_ac_snoop_i;
                r_prot    <= slv_ac_prot_i;
                r_resp    <= '0;
                r_src     <= '0;
                r_pend_ac <= w_eff_mask;
                r_pend_cr <= w_eff_mask;
            end else if (r_state == WAIT) begin
                r_pend_ac <= w_pend_ac_nxt;
                r_pend_cr <= w_pend_cr_nxt;
                r_resp    <= w_resp_nxt;
                r_src     <= w_src_nxt;
            end
        end
    end
endmodule

// File: tb/tb_snoop_ac_multicast.sv
// tb_snoop_ac_multicast: directed tests of snoop fan-out, response merging, DVM broadcast and reset.
module tb_snoop_ac_multicast;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        slv_ac_valid_i = 1'b0, slv_ac_ready_o;
    logic [63:0] slv_ac_addr_i = '0;
    logic [3:0]  slv_ac_snoop_i = '0;
    logic [2:0]  slv_ac_prot_i = '0;
    logic [3:0]  slv_ac_mask_i = '0;
    logic [3:0]  mst_ac_valid_o, mst_ac_ready_i = '0;
    logic [63:0] mst_ac_addr_o;
    logic [3:0]  mst_ac_snoop_o;
    logic [2:0]  mst_ac_prot_o;
    logic [3:0]  mst_cr_valid_i = '0, mst_cr_ready_o;
    logic [19:0] mst_cr_resp_i = '0;
    logic        slv_cr_valid_o, slv_cr_ready_i = 1'b0;
    logic [4:0]  slv_cr_resp_o;
    logic [3:0]  slv_cr_src_o;
    logic        busy_o;
    logic        b_ac_valid = 1'b0, b_ac_ready, b_cr_valid, b_cr_ready = 1'b0, b_busy;
    logic [3:0]  b_mst_ac_valid, b_mst_cr_ready, b_src, b_snoop;
    logic [63:0] b_addr;
    logic [2:0]  b_prot;
    logic [4:0]  b_resp;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    snoop_ac_multicast u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .slv_ac_valid_i(slv_ac_valid_i), .slv_ac_ready_o(slv_ac_ready_o),
        .slv_ac_addr_i(slv_ac_addr_i), .slv_ac_snoop_i(slv_ac_snoop_i),
        .slv_ac_prot_i(slv_ac_prot_i), .slv_ac_mask_i(slv_ac_mask_i),
        .mst_ac_valid_o(mst_ac_valid_o), .mst_ac_ready_i(mst_ac_ready_i),
        .mst_ac_addr_o(mst_ac_addr_o), .mst_ac_snoop_o(mst_ac_snoop_o), .mst_ac_prot_o(mst_ac_prot_o),
        .mst_cr_valid_i(mst_cr_valid_i), .mst_cr_ready_o(mst_cr_ready_o), .mst_cr_resp_i(mst_cr_resp_i),
        .slv_cr_valid_o(slv_cr_valid_o), .slv_cr_ready_i(slv_cr_ready_i),
        .slv_cr_resp_o(slv_cr_resp_o), .slv_cr_src_o(slv_cr_src_o), .busy_o(busy_o)
    );

    snoop_ac_multicast #(.DvmBroadcast(1'b0)) u_dut_nb (
        .clk_i(clk), .rst_i(rst_i),
        .slv_ac_valid_i(b_ac_valid), .slv_ac_ready_o(b_ac_ready),
        .slv_ac_addr_i(slv_ac_addr_i), .slv_ac_snoop_i(slv_ac_snoop_i),
        .slv_ac_prot_i(slv_ac_prot_i), .slv_ac_mask_i(slv_ac_mask_i),
        .mst_ac_valid_o(b_mst_ac_valid), .mst_ac_ready_i(mst_ac_ready_i),
        .mst_ac_addr_o(b_addr), .mst_ac_snoop_o(b_snoop), .mst_ac_prot_o(b_prot),
        .mst_cr_valid_i(mst_cr_valid_i), .mst_cr_ready_o(b_mst_cr_ready), .mst_cr_resp_i(mst_cr_resp_i),
        .slv_cr_valid_o(b_cr_valid), .slv_cr_ready_i(b_cr_ready),
        .slv_cr_resp_o(b_resp), .slv_cr_src_o(b_src), .busy_o(b_busy)
    );

    // Issues one snoop with every master's CR valid held high; port 3 AC ready comes dly3 cycles late.
    task automatic do_snoop(input logic [3:0] mask, input logic [3:0] snoop, input int dly3,
                            input logic [19:0] resps, input int hold, output int lat,
                            output logic [4:0] resp, output logic [3:0] src,
                            output logic [3:0] ac_seen, output logic ok);
        logic [63:0] a;
        a = {$urandom, $urandom};
        ok = 1'b1; ac_seen = '0; lat = -1; resp = '0; src = '0;
        mst_cr_resp_i = resps; mst_cr_valid_i = 4'b1111; mst_ac_ready_i = 4'b0111;
        slv_ac_valid_i = 1'b1; slv_ac_mask_i = mask; slv_ac_snoop_i = snoop;
        slv_ac_addr_i = a; slv_ac_prot_i = 3'b010; slv_cr_ready_i = 1'b0;
        if (slv_ac_ready_o !== 1'b1) ok = 1'b0;
        @(negedge clk);
        slv_ac_valid_i = 1'b0; slv_ac_addr_i = '0; slv_ac_snoop_i = '0; slv_ac_prot_i = '0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            if (c >= 1 + dly3) mst_ac_ready_i[3] = 1'b1;
            if ((mst_cr_ready_o & ~ac_seen) != 4'b0 || slv_ac_ready_o !== 1'b0) ok = 1'b0;
            if (mst_ac_addr_o !== a || mst_ac_snoop_o !== snoop || mst_ac_prot_o !== 3'b010) ok = 1'b0;
            ac_seen = ac_seen | mst_ac_valid_o;
            if (slv_cr_valid_o === 1'b1) begin
                lat = c; resp = slv_cr_resp_o; src = slv_cr_src_o;
            end else @(negedge clk);
        end
        if (lat >= 0) begin
            repeat (hold) begin
                @(negedge clk);
                if (slv_cr_valid_o !== 1'b1 || slv_cr_resp_o !== resp || slv_cr_src_o !== src ||
                    slv_ac_ready_o !== 1'b0) ok = 1'b0;
            end
            slv_cr_ready_i = 1'b1;
            @(negedge clk);
            slv_cr_ready_i = 1'b0;
            if (slv_ac_ready_o !== 1'b1 || slv_cr_valid_o !== 1'b0 || busy_o !== 1'b0) ok = 1'b0;
        end
        mst_cr_valid_i = '0; mst_ac_ready_i = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (slv_ac_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ac_ready got %b exp 0", slv_ac_ready_o); end
        tests++; if ({slv_cr_valid_o, busy_o, mst_ac_valid_o, mst_cr_ready_o} !== 10'b0) begin
            fails++; $display("FAIL reset_outputs got %b exp 0", {slv_cr_valid_o, busy_o, mst_ac_valid_o, mst_cr_ready_o}); end
        tests++; if ({slv_cr_resp_o, slv_cr_src_o, mst_ac_addr_o} !== 73'b0) begin
            fails++; $display("FAIL reset_data got %h exp 0", {slv_cr_resp_o, slv_cr_src_o, mst_ac_addr_o}); end
        rst_i = 1'b0;
        @(negedge clk);
        tests++; if (slv_ac_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            fails++; $display("FAIL reset_release ready/busy got %b%b exp 10", slv_ac_ready_o, busy_o); end
    endtask

    task automatic test_multicast();
        int lat; logic [4:0] r; logic [3:0] s, seen; logic ok;
        do_snoop(4'b0101, 4'b0001, 0, {5'b10111, 5'b00000, 5'b10111, 5'b01000}, 3, lat, r, s, seen, ok);
        tests++; if (lat !== 3) begin fails++; $display("FAIL multicast_latency got %0d exp 3", lat); end
        tests++; if (r !== 5'b01000) begin fails++; $display("FAIL multicast_resp got %b exp 01000", r); end
        tests++; if (s !== 4'b0000) begin fails++; $display("FAIL multicast_src got %b exp 0000", s); end
        tests++; if (seen !== 4'b0101) begin fails++; $display("FAIL multicast_ac_ports got %b exp 0101", seen); end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL multicast_protocol got %b exp 1", ok); end
    endtask

    task automatic test_delayed_port();
        int lat; logic [4:0] r; logic [3:0] s, seen; logic ok;
        do_snoop(4'b1111, 4'b0111, 5, {5'b0, 5'b0, 5'b00101, 5'b0}, 0, lat, r, s, seen, ok);
        tests++; if (lat !== 8) begin fails++; $display("FAIL delayed_latency got %0d exp 8", lat); end
        tests++; if (r !== 5'b00101) begin fails++; $display("FAIL delayed_resp got %b exp 00101", r); end
        tests++; if (s !== 4'b0010) begin fails++; $display("FAIL delayed_src got %b exp 0010", s); end
        tests++; if (ok !== 1'b1 || seen !== 4'b1111) begin fails++; $display("FAIL delayed_protocol got %b/%b exp 1/1111", ok, seen); end
    endtask

    task automatic test_pass_dirty();
        int lat; logic [4:0] r; logic [3:0] s, seen; logic ok;
        do_snoop(4'b1111, 4'b0001, 0, {5'b0, 5'b00100, 5'b0, 5'b00100}, 0, lat, r, s, seen, ok);
        tests++; if (r !== 5'b00110 || lat !== 3) begin fails++; $display("FAIL dirty_same_cycle got %b lat %0d exp 00110 lat 3", r, lat); end
        do_snoop(4'b1111, 4'b0001, 2, {5'b00100, 5'b0, 5'b0, 5'b00100}, 0, lat, r, s, seen, ok);
        tests++; if (r !== 5'b00110 || lat !== 5) begin fails++; $display("FAIL dirty_split_cycle got %b lat %0d exp 00110 lat 5", r, lat); end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL dirty_protocol got %b exp 1", ok); end
    endtask

    task automatic test_dvm_and_empty();
        int lat; logic [4:0] r; logic [3:0] s, seen; logic ok;
        do_snoop(4'b0000, 4'b1111, 0, {5'b0, 5'b01000, 5'b0, 5'b00001}, 0, lat, r, s, seen, ok);
        tests++; if (seen !== 4'b1111 || lat !== 3) begin fails++; $display("FAIL dvm_msg_bcast got %b lat %0d exp 1111 lat 3", seen, lat); end
        tests++; if (r !== 5'b01001 || s !== 4'b0001) begin fails++; $display("FAIL dvm_msg_resp got %b/%b exp 01001/0001", r, s); end
        do_snoop(4'b0000, 4'b1110, 0, 20'b0, 0, lat, r, s, seen, ok);
        tests++; if (seen !== 4'b1111 || r !== 5'b0) begin fails++; $display("FAIL dvm_cmpl_bcast got %b/%b exp 1111/00000", seen, r); end
        do_snoop(4'b0000, 4'b0001, 0, {5'b11111, 5'b11111, 5'b11111, 5'b11111}, 0, lat, r, s, seen, ok);
        tests++; if (lat !== 1 || seen !== 4'b0 || r !== 5'b0) begin fails++; $display("FAIL empty_mask got lat %0d ac %b resp %b exp lat 1 ac 0000 resp 0", lat, seen, r); end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL dvm_protocol got %b exp 1", ok); end
        slv_ac_snoop_i = 4'b1111; slv_ac_mask_i = 4'b0000; mst_ac_ready_i = 4'b1111;
        tests++; if (b_ac_ready !== 1'b1) begin fails++; $display("FAIL nobcast_ready got %b exp 1", b_ac_ready); end
        b_ac_valid = 1'b1;
        @(negedge clk);
        b_ac_valid = 1'b0;
        tests++; if (b_cr_valid !== 1'b1 || b_mst_ac_valid !== 4'b0 || b_resp !== 5'b0 || b_src !== 4'b0) begin
            fails++; $display("FAIL nobcast_resp got v%b ac %b resp %b src %b exp v1 ac 0000 resp 0 src 0", b_cr_valid, b_mst_ac_valid, b_resp, b_src); end
        b_cr_ready = 1'b1;
        @(negedge clk);
        b_cr_ready = 1'b0; mst_ac_ready_i = '0;
        tests++; if (b_ac_ready !== 1'b1 || b_busy !== 1'b0) begin fails++; $display("FAIL nobcast_idle got %b%b exp 10", b_ac_ready, b_busy); end
    endtask

    task automatic test_cr_timing();
        slv_ac_valid_i = 1'b1; slv_ac_mask_i = 4'b0001; slv_ac_snoop_i = 4'b0001;
        mst_ac_ready_i = 4'b0001; mst_cr_resp_i = {5'b0, 5'b0, 5'b0, 5'b10000};
        @(negedge clk);
        slv_ac_valid_i = 1'b0; mst_cr_valid_i = 4'b1111;
        tests++; if (mst_ac_valid_o !== 4'b0001 || mst_cr_ready_o !== 4'b0000) begin
            fails++; $display("FAIL cr_same_cycle got ac %b cr_ready %b exp 0001/0000", mst_ac_valid_o, mst_cr_ready_o); end
        @(negedge clk);
        tests++; if (mst_ac_valid_o !== 4'b0000 || mst_cr_ready_o !== 4'b0001) begin
            fails++; $display("FAIL cr_next_cycle got ac %b cr_ready %b exp 0000/0001", mst_ac_valid_o, mst_cr_ready_o); end
        @(negedge clk);
        mst_cr_valid_i = '0; mst_ac_ready_i = '0;
        tests++; if (slv_cr_valid_o !== 1'b1 || slv_cr_resp_o !== 5'b10000 || mst_cr_ready_o !== 4'b0) begin
            fails++; $display("FAIL cr_merged got v%b resp %b rdy %b exp v1 resp 10000 rdy 0000", slv_cr_valid_o, slv_cr_resp_o, mst_cr_ready_o); end
        slv_cr_ready_i = 1'b1;
        @(negedge clk);
        slv_cr_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat; logic [4:0] r; logic [3:0] s, seen; logic ok;
        slv_ac_valid_i = 1'b1; slv_ac_mask_i = 4'b1111; slv_ac_snoop_i = 4'b0001; mst_ac_ready_i = '0;
        @(negedge clk);
        slv_ac_valid_i = 1'b0;
        @(negedge clk);
        tests++; if (busy_o !== 1'b1 || mst_ac_valid_o !== 4'b1111) begin
            fails++; $display("FAIL midrst_wait got busy %b ac %b exp 1/1111", busy_o, mst_ac_valid_o); end
        #2 rst_i = 1'b1;
        #1;
        tests++; if ({busy_o, mst_ac_valid_o, slv_ac_ready_o, slv_cr_valid_o, mst_cr_ready_o} !== 11'b0) begin
            fails++; $display("FAIL midrst_async got %b exp 0", {busy_o, mst_ac_valid_o, slv_ac_ready_o, slv_cr_valid_o, mst_cr_ready_o}); end
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        tests++; if (slv_ac_ready_o !== 1'b1 || busy_o !== 1'b0 || slv_cr_valid_o !== 1'b0) begin
            fails++; $display("FAIL midrst_idle got rdy %b busy %b v %b exp 1/0/0", slv_ac_ready_o, busy_o, slv_cr_valid_o); end
        do_snoop(4'b0110, 4'b0001, 0, {5'b0, 5'b00001, 5'b01000, 5'b0}, 1, lat, r, s, seen, ok);
        tests++; if (lat !== 3 || r !== 5'b01001 || s !== 4'b0100 || ok !== 1'b1) begin
            fails++; $display("FAIL midrst_recover got lat %0d resp %b src %b ok %b exp 3/01001/0100/1", lat, r, s, ok); end
    endtask

    initial begin
        test_reset();
        test_multicast();
        test_delayed_port();
        test_pass_dirty();
        test_dvm_and_empty();
        test_cr_timing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
